// File: rtl/wb_dma_pkg.sv
// ============================================================
// wb_dma_pkg : register map, CTRL bit indices and FSM encodings
// Rev 1.0
// ============================================================
`default_nettype none

package wb_dma_pkg;

    localparam logic [1:0] REG_SRC  = 2'd0;
    localparam logic [1:0] REG_DST  = 2'd1;
    localparam logic [1:0] REG_LEN  = 2'd2;
    localparam logic [1:0] REG_CTRL = 2'd3;

    localparam int CTRL_START   = 0;
    localparam int CTRL_BUSY    = 1;
    localparam int CTRL_DONE    = 2;
    localparam int CTRL_ERR     = 3;
    localparam int CTRL_IRQ_EN  = 4;
    localparam int CTRL_ABORT   = 5;
    localparam int CTRL_SRC_FIX = 6;
    localparam int CTRL_DST_FIX = 7;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_GAP1 = 3'd2,
        ST_WR   = 3'd3,
        ST_GAP2 = 3'd4,
        ST_DONE = 3'd5
    } state_t;

endpackage

`default_nettype wire

// File: rtl/wb_dma_regs.sv
// ============================================================
// wb_dma_regs : slave decode, register file, ack and interrupt
// Rev 1.0
// ============================================================
`default_nettype none

module wb_dma_regs
    import wb_dma_pkg::*;
#(
    parameter int LEN_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          wb_adr_i,
    input  logic [31:0]          wb_dat_i,
    input  logic [3:0]           wb_sel_i,
    input  logic                 wb_stb_i,
    input  logic                 wb_cyc_i,
    input  logic                 wb_we_i,
    output logic [31:0]          wb_dat_o,
    output logic                 wb_ack_o,
    input  logic                 busy,
    input  logic                 advance,
    input  logic                 set_done,
    input  logic                 set_err,
    output logic [31:0]          src,
    output logic [31:0]          dst,
    output logic [LEN_WIDTH-1:0] len,
    output logic                 start_go,
    output logic                 abort_req,
    output logic                 intr
);

    logic                 access, wr_en, ctrl_wr, start_req;
    logic [1:0]           reg_sel;
    logic                 done, err, irq_en, src_fix, dst_fix;
    logic                 done_next, err_next, irq_en_next, src_fix_next, dst_fix_next;
    logic [31:0]          src_next, dst_next, rdata;
    logic [LEN_WIDTH-1:0] len_next;
    logic                 unused;

    assign unused    = &{1'b0, wb_sel_i, wb_adr_i[31:4], wb_adr_i[1:0]};
    assign reg_sel   = wb_adr_i[3:2];
    assign access    = wb_stb_i & wb_cyc_i & ~wb_ack_o;
    assign wr_en     = access & wb_we_i;
    assign ctrl_wr   = wr_en & (reg_sel == REG_CTRL);
    assign start_req = ctrl_wr & wb_dat_i[CTRL_START] & ~busy;
    assign start_go  = start_req & (len != '0);
    assign abort_req = ctrl_wr & wb_dat_i[CTRL_ABORT] & busy;

    // W1C clears are applied before any set, so START+clear-DONE in one write restarts cleanly
    always_comb begin
        src_next     = src;
        dst_next     = dst;
        len_next     = len;
        done_next    = done;
        err_next     = err;
        irq_en_next  = irq_en;
        src_fix_next = src_fix;
        dst_fix_next = dst_fix;
        if (wr_en && !busy) begin
            case (reg_sel)
                REG_SRC: src_next = {wb_dat_i[31:2], 2'b00};
                REG_DST: dst_next = {wb_dat_i[31:2], 2'b00};
                REG_LEN: len_next = wb_dat_i[LEN_WIDTH-1:0];
                default: ;
            endcase
        end
        if (ctrl_wr) begin
            if (wb_dat_i[CTRL_DONE]) done_next = 1'b0;
            if (wb_dat_i[CTRL_ERR])  err_next  = 1'b0;
            irq_en_next  = wb_dat_i[CTRL_IRQ_EN];
            src_fix_next = wb_dat_i[CTRL_SRC_FIX];
            dst_fix_next = wb_dat_i[CTRL_DST_FIX];
        end
        if ((start_req && (len == '0)) || set_done) done_next = 1'b1;
        if (set_err) err_next = 1'b1;
        if (advance) begin
            len_next = len - 1'b1;
            if (!src_fix) src_next = src + 32'd4;
            if (!dst_fix) dst_next = dst + 32'd4;
        end
    end

    always_comb begin
        rdata = '0;
        case (reg_sel)
            REG_SRC: rdata = src;
            REG_DST: rdata = dst;
            REG_LEN: rdata = 32'(len);
            default: begin
                rdata[CTRL_BUSY]    = busy;
                rdata[CTRL_DONE]    = done;
                rdata[CTRL_ERR]     = err;
                rdata[CTRL_IRQ_EN]  = irq_en;
                rdata[CTRL_SRC_FIX] = src_fix;
                rdata[CTRL_DST_FIX] = dst_fix;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src      <= '0;
            dst      <= '0;
            len      <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            irq_en   <= 1'b0;
            src_fix  <= 1'b0;
            dst_fix  <= 1'b0;
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
            intr     <= 1'b0;
        end else begin
            src      <= src_next;
            dst      <= dst_next;
            len      <= len_next;
            done     <= done_next;
            err      <= err_next;
            irq_en   <= irq_en_next;
            src_fix  <= src_fix_next;
            dst_fix  <= dst_fix_next;
            wb_ack_o <= access;
            if (access && !wb_we_i) wb_dat_o <= rdata;
            // built from next-state bits so intr tracks DONE/ERR on the same edge
            intr     <= irq_en_next & (done_next | err_next);
        end
    end

endmodule

`default_nettype wire

// File: rtl/wb_dma.sv
// ============================================================
// wb_dma : Wishbone block-copy DMA, top level and master FSM
// Rev 1.0
// ============================================================
`default_nettype none

module wb_dma
    import wb_dma_pkg::*;
#(
    parameter int LEN_WIDTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    input  logic        wb_we_i,
    output logic        wb_ack_o,
    output logic [31:0] m_adr_o,
    output logic [31:0] m_dat_o,
    input  logic [31:0] m_dat_i,
    output logic [3:0]  m_sel_o,
    output logic        m_we_o,
    output logic        m_cyc_o,
    output logic        m_stb_o,
    input  logic        m_ack_i,
    input  logic        m_err_i,
    output logic        intr
);

    state_t               state, state_next;
    logic                 busy, advance, set_done, set_err, start_go, abort_req, abort_pend;
    logic [31:0]          src, dst, buffer;
    logic [LEN_WIDTH-1:0] len;

    wb_dma_regs #(.LEN_WIDTH(LEN_WIDTH)) u_regs (
        .clk       (clk),
        .reset     (reset),
        .wb_adr_i  (wb_adr_i),
        .wb_dat_i  (wb_dat_i),
        .wb_sel_i  (wb_sel_i),
        .wb_stb_i  (wb_stb_i),
        .wb_cyc_i  (wb_cyc_i),
        .wb_we_i   (wb_we_i),
        .wb_dat_o  (wb_dat_o),
        .wb_ack_o  (wb_ack_o),
        .busy      (busy),
        .advance   (advance),
        .set_done  (set_done),
        .set_err   (set_err),
        .src       (src),
        .dst       (dst),
        .len       (len),
        .start_go  (start_go),
        .abort_req (abort_req),
        .intr      (intr)
    );

    assign busy = (state != ST_IDLE);

    always_comb begin
        state_next = state;
        advance    = 1'b0;
        set_done   = 1'b0;
        set_err    = 1'b0;
        case (state)
            ST_IDLE: if (start_go) state_next = ST_RD;
            ST_RD: begin
                if (m_err_i) begin
                    set_err    = 1'b1;
                    state_next = ST_IDLE;
                end else if (m_ack_i) begin
                    state_next = ST_GAP1;
                end
            end
            ST_GAP1: state_next = abort_pend ? ST_IDLE : ST_WR;
            ST_WR: begin
                if (m_err_i) begin
                    set_err    = 1'b1;
                    state_next = ST_IDLE;
                end else if (m_ack_i) begin
                    advance    = 1'b1;
                    state_next = (len == LEN_WIDTH'(1)) ? ST_DONE : ST_GAP2;
                end
            end
            ST_GAP2: state_next = abort_pend ? ST_IDLE : ST_RD;
            ST_DONE: begin
                set_done   = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            abort_pend <= 1'b0;
            buffer     <= '0;
        end else begin
            state <= state_next;
            // abort only takes effect at a gap, so the in-flight cycle always completes
            if (state_next == ST_IDLE) abort_pend <= 1'b0;
            else if (abort_req)        abort_pend <= 1'b1;
            if ((state == ST_RD) && m_ack_i && !m_err_i) buffer <= m_dat_i;
        end
    end

    // Outputs decode straight from state so an async reset releases the bus at once
    assign m_cyc_o = (state == ST_RD) || (state == ST_WR);
    assign m_stb_o = m_cyc_o;
    assign m_we_o  = (state == ST_WR);
    assign m_sel_o = m_cyc_o ? 4'hF : 4'h0;
    assign m_adr_o = (state == ST_WR) ? dst : ((state == ST_RD) ? src : '0);
    assign m_dat_o = (state == ST_WR) ? buffer : '0;

endmodule

`default_nettype wire

// File: tb/tb_wb_dma.sv
// ============================================================
// tb_wb_dma : scoreboard bench for wb_dma with memory-model slave
// Rev 1.0
// ============================================================
`default_nettype none

module tb_wb_dma;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
    logic [3:0]  wb_sel_i;
    logic        wb_stb_i, wb_cyc_i, wb_we_i, wb_ack_o;
    logic [31:0] m_adr_o, m_dat_o, m_dat_i;
    logic [3:0]  m_sel_o;
    logic        m_we_o, m_cyc_o, m_stb_o, m_ack_i, m_err_i, intr;

    int errors = 0;
    int checks = 0;
    int read_count = 0;
    int wr_count = 0;
    int cyc_cycles = 0;
    int err_on_read = 0;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] wq_adr[$];
    logic [31:0] wq_dat[$];
    logic [31:0] rq_val[$];
    int          rq_tag[$];
    logic [31:0] ea, ed;
    int          et;

    wb_dma #(.LEN_WIDTH(16)) dut (
        .clk(clk), .reset(reset),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_sel_i(wb_sel_i),
        .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_we_i(wb_we_i), .wb_ack_o(wb_ack_o),
        .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i), .m_sel_o(m_sel_o),
        .m_we_o(m_we_o), .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_ack_i(m_ack_i),
        .m_err_i(m_err_i), .intr(intr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    // Zero-wait memory slave; a read chosen by err_on_read answers err and ack together
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_ack_i <= 1'b0;
            m_err_i <= 1'b0;
            m_dat_i <= '0;
        end else begin
            m_ack_i <= 1'b0;
            m_err_i <= 1'b0;
            if (m_cyc_o && m_stb_o && !m_ack_i && !m_err_i) begin
                m_ack_i <= 1'b1;
                if (!m_we_o) begin
                    read_count <= read_count + 1;
                    m_dat_i    <= mem_read(m_adr_o);
                    if (err_on_read != 0 && read_count + 1 == err_on_read) m_err_i <= 1'b1;
                end
            end
        end
    end

    // Master write monitor: pops expected (address, data) per completed write
    always @(negedge clk) begin
        if (m_cyc_o) cyc_cycles++;
        if (!reset && m_cyc_o && m_stb_o && m_we_o && m_ack_i && !m_err_i) begin
            wr_count++;
            chk("m_sel", 32'(m_sel_o), 32'hF);
            if (wq_adr.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got adr %h dat %h required no write", m_adr_o, m_dat_o);
            end else begin
                ea = wq_adr.pop_front();
                ed = wq_dat.pop_front();
                chk("wr_adr", m_adr_o, ea);
                chk("wr_dat", m_dat_o, ed);
            end
            mem[m_adr_o] = m_dat_o;
        end
    end

    // Slave read monitor
    always @(negedge clk) begin
        if (wb_ack_o && !wb_we_i) begin
            if (rq_val.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_read_ack: got %h required none", wb_dat_o);
            end else begin
                ed = rq_val.pop_front();
                et = rq_tag.pop_front();
                checks++;
                if (wb_dat_o !== ed) begin
                    errors++;
                    $display("FAIL reg_read tag=%0d: got %h required %h", et, wb_dat_o, ed);
                end
            end
        end
    end

    task automatic bus(input logic we, input logic [1:0] a, input logic [31:0] d);
        int n;
        wb_adr_i = {28'h0, a, 2'b00};
        wb_dat_i = d;
        wb_we_i  = we;
        wb_stb_i = 1'b1;
        wb_cyc_i = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!wb_ack_o && n < 20);
        if (!wb_ack_o) chk("slave_ack_timeout", 32'(wb_ack_o), 32'h1);
        #1;
        wb_stb_i = 1'b0;
        wb_cyc_i = 1'b0;
        wb_we_i  = 1'b0;
    endtask

    task automatic reg_wr(input logic [1:0] a, input logic [31:0] d);
        bus(1'b1, a, d);
    endtask

    task automatic reg_rd(input logic [1:0] a, input logic [31:0] exp, input int tag);
        rq_val.push_back(exp);
        rq_tag.push_back(tag);
        bus(1'b0, a, 32'h0);
    endtask

    task automatic wait_intr(input int max, output int cyc);
        cyc = 0;
        while (!intr && cyc < max) begin
            @(negedge clk);
            cyc++;
        end
        chk("intr_raised", 32'(intr), 32'h1);
    endtask

    task automatic push_words(input logic [31:0] s, input logic [31:0] d, input int n,
                              input bit sf, input bit df);
        for (int i = 0; i < n; i++) begin
            wq_adr.push_back(df ? d : d + 32'(4 * i));
            wq_dat.push_back(mem_read(sf ? s : s + 32'(4 * i)));
        end
    endtask

    task automatic run_xfer(input logic [31:0] s, input logic [31:0] d, input int n,
                            input bit sf, input bit df, input int tag, output int cyc);
        logic [31:0] sa, da;
        sa = s & ~32'h3;
        da = d & ~32'h3;
        reg_wr(2'd0, s);
        reg_wr(2'd1, d);
        reg_wr(2'd2, 32'(n));
        push_words(sa, da, n, sf, df);
        reg_wr(2'd3, {24'h0, df, sf, 6'b011101});
        wait_intr(400, cyc);
        chk("writes_drained", 32'(wq_adr.size()), 32'h0);
        reg_rd(2'd0, sf ? sa : sa + 32'(4 * n), tag);
        reg_rd(2'd1, df ? da : da + 32'(4 * n), tag);
        reg_rd(2'd2, 32'h0, tag);
        reg_rd(2'd3, {24'h0, df, sf, 6'b010100}, tag);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, n, base, rbase, wbase;
        logic [31:0] s, d;
        reset    = 1'b1;
        wb_adr_i = '0;
        wb_dat_i = '0;
        wb_sel_i = 4'hF;
        wb_stb_i = 1'b0;
        wb_cyc_i = 1'b0;
        wb_we_i  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_m_cyc", 32'(m_cyc_o), 32'h0);
        chk("rst_m_adr", m_adr_o, 32'h0);
        chk("rst_ack", 32'(wb_ack_o), 32'h0);
        chk("rst_dat_o", wb_dat_o, 32'h0);
        chk("rst_intr", 32'(intr), 32'h0);
        reset = 1'b0;
        @(negedge clk);
        for (int r = 0; r < 4; r++) reg_rd(2'(r), 32'h0, 0);

        // Zero-length start: no bus activity, DONE and intr one cycle later
        base = cyc_cycles;
        reg_wr(2'd2, 32'h0);
        reg_wr(2'd3, 32'h1D);
        chk("len0_intr", 32'(intr), 32'h1);
        reg_rd(2'd3, 32'h14, 1);
        repeat (5) @(negedge clk);
        chk("len0_no_cyc", 32'(cyc_cycles - base), 32'h0);
        reg_wr(2'd3, 32'h14);
        chk("w1c_intr_drop", 32'(intr), 32'h0);

        // Basic 4-word copy with timing
        mem[32'h100] = 32'h11;
        mem[32'h104] = 32'h22;
        mem[32'h108] = 32'h33;
        mem[32'h10C] = 32'h44;
        run_xfer(32'h100, 32'h40000000, 4, 1'b0, 1'b0, 2, cyc);
        checks++;
        if (cyc < 22 || cyc > 26) begin
            errors++;
            $display("FAIL xfer4_cycles: got %0d required 24+-2", cyc);
        end
        chk("sram0", mem_read(32'h40000000), 32'h11);
        chk("sram3", mem_read(32'h4000000C), 32'h44);

        // Fixed destination
        run_xfer(32'h200, 32'h70004000, 3, 1'b0, 1'b1, 3, cyc);

        // Bus error on the second read (ack and err together: err wins)
        rbase = read_count;
        err_on_read = rbase + 2;
        reg_wr(2'd0, 32'h5000);
        reg_wr(2'd1, 32'hB0000000);
        reg_wr(2'd2, 32'd4);
        push_words(32'h5000, 32'hB0000000, 1, 1'b0, 1'b0);
        reg_wr(2'd3, 32'h1D);
        n = 0;
        while (!m_err_i && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("err_seen", 32'(m_err_i), 32'h1);
        @(negedge clk);
        chk("err_cyc_drop", 32'(m_cyc_o), 32'h0);
        wait_intr(20, cyc);
        reg_rd(2'd0, 32'h5004, 4);
        reg_rd(2'd1, 32'hB0000004, 4);
        reg_rd(2'd2, 32'd3, 4);
        reg_rd(2'd3, 32'h18, 4);
        err_on_read = 0;

        // Abort during the write of word 2 of 8
        rbase = read_count;
        wbase = wr_count;
        reg_wr(2'd0, 32'h2000);
        reg_wr(2'd1, 32'h90000000);
        reg_wr(2'd2, 32'd8);
        push_words(32'h2000, 32'h90000000, 2, 1'b0, 1'b0);
        reg_wr(2'd3, 32'h1D);
        n = 0;
        while (!(m_cyc_o && m_we_o && !m_ack_i && wr_count == wbase + 1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reach_wr2", 32'(m_we_o), 32'h1);
        reg_wr(2'd3, 32'h30);
        repeat (20) @(negedge clk);
        chk("abort_reads", 32'(read_count - rbase), 32'd2);
        chk("abort_idle", 32'(m_cyc_o), 32'h0);
        chk("abort_no_intr", 32'(intr), 32'h0);
        chk("abort_writes_drained", 32'(wq_adr.size()), 32'h0);
        reg_rd(2'd2, 32'd6, 5);
        reg_rd(2'd0, 32'h2008, 5);
        reg_rd(2'd3, 32'h10, 5);

        // Asynchronous reset in the middle of a write
        wbase = wr_count;
        reg_wr(2'd0, 32'h3000);
        reg_wr(2'd1, 32'hA0000000);
        reg_wr(2'd2, 32'd4);
        push_words(32'h3000, 32'hA0000000, 4, 1'b0, 1'b0);
        reg_wr(2'd3, 32'h1D);
        n = 0;
        while (!(m_cyc_o && m_we_o && wr_count == wbase + 1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rst_reach_wr", 32'(m_we_o), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_cyc", 32'(m_cyc_o), 32'h0);
        chk("async_rst_stb", 32'(m_stb_o), 32'h0);
        wq_adr.delete();
        wq_dat.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_intr", 32'(intr), 32'h0);
        for (int r = 0; r < 4; r++) reg_rd(2'(r), 32'h0, 6);

        // Randomized transfers, plus a source address that wraps past 2^32
        for (int k = 0; k < 6; k++) begin
            s = $urandom & 32'h0FFFFFFF;
            d = 32'h80000000 | ($urandom & 32'h0FFFFFFF);
            run_xfer(s, d, $urandom_range(1, 6), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 10 + k, cyc);
        end
        run_xfer(32'hFFFFFFF8, 32'h7FFFFFFC, 3, 1'b0, 1'b0, 20, cyc);

        repeat (3) @(negedge clk);
        chk("reads_drained", 32'(rq_val.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
